// File: rtl/binary_multiplier_pkg.sv
// Shared control definitions for the multiplier and divider datapaths, so one
// sequencer can decode either block's state.
package binary_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Divider encoding matches the multiplier so a sequencer can treat both alike.
  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  localparam int MUL_WIDTH_A = 16;
  localparam int MUL_WIDTH_B = 8;

endpackage

// File: rtl/binary_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per clock, fixed latency
// of WIDTH_B cycles, with a level-held enable / ready handshake.
module binary_multiplier
  import binary_multiplier_pkg::*;
#(
  parameter int WIDTH_A = MUL_WIDTH_A,
  parameter int WIDTH_B = MUL_WIDTH_B
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [WIDTH_A-1:0]         g_multiplicand_Q,
  input  logic [WIDTH_B-1:0]         g_multiplier_Q,
  output logic [WIDTH_A+WIDTH_B-1:0] product,
  output logic                       ready
);

  localparam int PW    = WIDTH_A + WIDTH_B;
  localparam int CNT_W = $clog2(WIDTH_B) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH_B - 1);

  mul_state_t         state, state_next;
  logic [PW-1:0]      a_reg, acc, acc_next;
  logic [WIDTH_B-1:0] b_reg;
  logic [CNT_W-1:0]   cnt;
  logic               load, step, finish;

  assign acc_next = acc + (b_reg[0] ? a_reg : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          load       = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (!enable) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == LAST) begin
            finish     = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (!enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operands latched on load, then one conditional add and shift per step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
      ready   <= 1'b0;
    end else begin
      if (load) begin
        a_reg <= PW'(g_multiplicand_Q);
        b_reg <= g_multiplier_Q;
        acc   <= '0;
        cnt   <= '0;
      end else if (step) begin
        acc   <= acc_next;
        a_reg <= a_reg << 1;
        b_reg <= b_reg >> 1;
        cnt   <= cnt + 1'b1;
      end
      if (finish) product <= acc_next;
      ready <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_binary_multiplier.sv
// Self-checking bench for binary_multiplier: expected products are queued when
// a request is driven and compared when ready rises.
module tb_binary_multiplier;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] g_multiplicand_Q;
  logic [7:0]  g_multiplier_Q;
  logic [23:0] product;
  logic        ready;

  int checks   = 0;
  int failures = 0;
  logic [23:0] scoreboard[$];
  logic [23:0] last_product;

  binary_multiplier dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .g_multiplicand_Q (g_multiplicand_Q),
    .g_multiplier_Q   (g_multiplier_Q),
    .product          (product),
    .ready            (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               tag, observed, observed, expected, expected);
    end
  endtask

  // Drive a request on a falling edge and queue the product it must produce.
  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    g_multiplicand_Q = a;
    g_multiplier_Q   = b;
    enable           = 1'b1;
    scoreboard.push_back(24'(a) * 24'(b));
  endtask

  // Wait from the load edge for ready, then check latency, result and handshake.
  task automatic waitResult(input string tag, input bit scramble);
    int n;
    logic [23:0] expected;
    @(posedge clk);
    if (scramble) begin
      #1;
      g_multiplicand_Q = 16'd3;
      g_multiplier_Q   = 8'd3;
    end
    n = 0;
    while (!ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_latency"}, 32'(n), 32'd8);
    expected = (scoreboard.size() > 0) ? scoreboard.pop_front() : 24'hx;
    checkOutput({tag, "_product"}, 32'(product), 32'(expected));
    repeat (3) @(negedge clk);
    checkOutput({tag, "_ready_hold"}, 32'(ready), 32'd1);
    checkOutput({tag, "_product_hold"}, 32'(product), 32'(expected));
    enable = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({tag, "_ready_drop"}, 32'(ready), 32'd0);
    checkOutput({tag, "_product_keep"}, 32'(product), 32'(expected));
    last_product = expected;
  endtask

  initial begin
    bit seen_ready;
    reset            = 1'b1;
    enable           = 1'b0;
    g_multiplicand_Q = '0;
    g_multiplier_Q   = '0;
    #12;
    checkOutput("reset_product", 32'(product), 32'd0);
    checkOutput("reset_ready", 32'(ready), 32'd0);
    reset = 1'b0;

    applyStimulus(16'd63, 8'd12);
    waitResult("roundtrip", 1'b0);

    // Abort after four busy cycles: no result, previous product retained.
    @(negedge clk);
    g_multiplicand_Q = 16'd100;
    g_multiplier_Q   = 8'd3;
    enable           = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    seen_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ready) seen_ready = 1'b1;
    end
    checkOutput("abort_ready", 32'(seen_ready), 32'd0);
    checkOutput("abort_product", 32'(product), 32'(last_product));

    applyStimulus(16'd5, 8'd7);
    waitResult("after_abort", 1'b0);

    applyStimulus(16'hFFFF, 8'hFF);
    waitResult("max", 1'b0);

    applyStimulus(16'd1234, 8'd0);
    waitResult("zero_b", 1'b0);

    applyStimulus(16'd0, 8'd200);
    waitResult("zero_a", 1'b0);

    applyStimulus(16'd5, 8'd7);
    waitResult("nonzero_prev", 1'b0);

    // Reset between edges while busy; enable stays high so a load follows release.
    @(negedge clk);
    g_multiplicand_Q = 16'd50;
    g_multiplier_Q   = 8'd50;
    enable           = 1'b1;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("midreset_product", 32'(product), 32'd0);
    checkOutput("midreset_ready", 32'(ready), 32'd0);
    g_multiplicand_Q = 16'd9;
    g_multiplier_Q   = 8'd9;
    scoreboard.push_back(24'd81);
    @(negedge clk);
    reset = 1'b0;
    waitResult("after_reset", 1'b0);

    applyStimulus(16'd10, 8'd10);
    waitResult("operand_change", 1'b1);

    applyStimulus(16'hABCD, 8'h81);
    waitResult("mixed", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/binary_multiplier.md
Name: binary_multiplier

Overview:
- Sequential shift-add multiplier; the inverse of binary_divider.
- Takes an 8-bit quotient-style multiplier and a 16-bit operand, and produces the full 24-bit product.
- Reconstructs or scales gradient values from divider quotients, e.g. checks that quotient × divisor ≤ dividend.
- Uses the same level-held enable / ready handshake as binary_divider, so both blocks share one control sequencer.

Parameters:
- WIDTH_A, 16, width of multiplicand g_multiplicand_Q.
- WIDTH_B, 8, width of multiplier g_multiplier_Q; also the iteration count.
- Product width is fixed at WIDTH_A+WIDTH_B; it is not a parameter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  level request; held high by the requester until ready is seen, then dropped.
- g_multiplicand_Q  input  WIDTH_A  unsigned multiplicand; sampled only at the load edge.
- g_multiplier_Q  input  WIDTH_B  unsigned multiplier; sampled only at the load edge.
- product  output  WIDTH_A+WIDTH_B  unsigned result, registered.
- ready  output  1  result valid, registered.

Behaviour:
- Reset (async, any time): state=IDLE, product=0, ready=0, internal accumulator/counter/operand registers=0.
- FSM states:
  - IDLE:
    - enable=1 → latch A=g_multiplicand_Q (zero-extended to product width), B=g_multiplier_Q; acc=0; cnt=0; go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY, each edge:
    - acc += (B[0] ? A : 0); A <<= 1; B >>= 1; cnt++.
    - On the edge where cnt==WIDTH_B-1: product<=acc_next, ready<=1, go to DONE.
  - DONE:
    - Hold product and ready=1 while enable=1.
    - enable=0 → ready<=0, go to IDLE; product keeps its last value.
- Latency: load edge L, ready and product visible after edge L+WIDTH_B (8 cycles for defaults). A new request costs at least 1 idle cycle: DONE→IDLE, then load.
- Abort: enable=0 while in BUSY → IDLE at next edge; ready stays 0; product not updated.
- Inputs changing during BUSY/DONE have no effect; operands are latched.
- No early termination on B==0: latency is constant regardless of operand values.
- Arithmetic is unsigned, no overflow possible: max (2^16-1)(2^8-1)=0xFEFF01 fits in 24 bits.
- A reset asserted mid-operation discards the computation; outputs return to 0 immediately.
- If enable is still high in IDLE right after reset deasserts, a load occurs at the first edge.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, BUSY=2'd1, DONE=2'd2). Place them alongside the divider's state constants so the sequencer can use both.
- Iteration counter width = clog2(WIDTH_B)+1 defined as a localparam.
- No sub-module: FSM plus single add/shift datapath in one module, ~150 lines.

Test Plan:
- Roundtrip: reset 5 ns, enable at 25 ns, A=63, B=12 → ready rises 8 cycles after load edge; product=756 (≤765, consistent with divider 765/63=12); ready holds until enable drops, then falls next edge.
- Max operands: A=16'hFFFF, B=8'hFF → product=24'hFEFF01 after 8 cycles.
- Zero: A=1234, B=0 → product=0, still exactly 8-cycle latency. A=0, B=200 → product=0.
- Abort: A=100, B=3, drop enable after 4 BUSY cycles → ready never asserts; product keeps previous value (e.g. 756 from prior test); FSM back in IDLE and next request A=5, B=7 yields 35.
- Reset mid-op: assert reset asynchronously between edges during BUSY → product=0, ready=0 immediately; after release, request A=9, B=9 → 81.
- Operand change during BUSY: load A=10, B=10, then change inputs to A=3, B=3 on the next cycle → product=100.
